// File: rtl/jogo_sequencias.sv
// jogo_sequencias: progressive sequence-memory ("Genius") game.
// A control FSM plus a datapath. In round r the player repeats ROM entries 0..r
// on the four buttons. The game ends in one of three ways: a win after the last
// round, a loss on a wrong button, or a timeout after too long without a press.
// Ports:
//   clock, reset (async, active-low)  - clock and reset
//   jogar                             - start request (level), seen only when idle or finished
//   botoes[3:0]                       - one-hot player buttons
//   modo                              - 1 = demo game, 0 = normal game; latched at start
//   ganhou / perdeu / timeout / pronto - held end-of-game flags
//   leds[3:0]                         - button echo while a press is held in espera
//   db_*                              - debug: comparator, 7-seg views, latched mode
//
// state         | code | meaning
// inicial       |  0   | idle after reset, waiting for jogar
// preparacao    |  1   | latch mode, clear round limit
// inicia_rodada |  2   | rewind address and timer for a new round
// espera        |  3   | wait for a press, count inactivity
// compara       |  4   | check captured press against ROM
// proximo       |  5   | advance to next entry of this round
// fim_rodada    |  6   | round complete: win or grow the sequence
// fim_acertou   |  A   | game won
// fim_errou     |  E   | wrong button
// fim_timeout   |  F   | inactivity timeout
module jogo_sequencias #(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int RODADAS_DEMO   = 4,
    parameter int RODADAS_NORMAL = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    input  logic       modo,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       timeout,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_limite_view,
    output logic       db_enderecoIgualLimite,
    output logic       db_timeout,
    output logic       db_modo
);

    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_FIM  = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [3:0]    ULT_DEMO   = 4'(RODADAS_DEMO - 1);
    localparam logic [3:0]    ULT_NORMAL = 4'(RODADAS_NORMAL - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        INICIA_RODADA = 4'h2,
        ESPERA        = 4'h3,
        COMPARA       = 4'h4,
        PROXIMO       = 4'h5,
        FIM_RODADA    = 4'h6,
        FIM_ACERTOU   = 4'hA,
        FIM_ERROU     = 4'hE,
        FIM_TIMEOUT   = 4'hF
    } estado_t;

    estado_t       estado, prox;
    logic [3:0]    endereco, limite, jogada_reg;
    logic [TW-1:0] timer;
    logic          modo_reg, botoes_ant, jogada;
    logic          carrega_modo, zera_lim, inc_lim, zera_end, inc_end;
    logic          zera_timer, inc_timer, carrega_jog;
    logic          acertou_jogada, fim_seq, ult_rodada, ativo;

    function automatic logic [3:0] rom(input logic [1:0] a);
        rom = 4'b0001 << a;
    endfunction

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'b1000000;
            4'h1: hex7seg = 7'b1111001;
            4'h2: hex7seg = 7'b0100100;
            4'h3: hex7seg = 7'b0110000;
            4'h4: hex7seg = 7'b0011001;
            4'h5: hex7seg = 7'b0010010;
            4'h6: hex7seg = 7'b0000010;
            4'h7: hex7seg = 7'b1111000;
            4'h8: hex7seg = 7'b0000000;
            4'h9: hex7seg = 7'b0010000;
            4'hA: hex7seg = 7'b0001000;
            4'hB: hex7seg = 7'b0000011;
            4'hC: hex7seg = 7'b1000110;
            4'hD: hex7seg = 7'b0100001;
            4'hE: hex7seg = 7'b0000110;
            default: hex7seg = 7'b0001110;
        endcase
    endfunction

    // Any-button rising edge: a held button produces a single press.
    assign jogada         = (|botoes) & ~botoes_ant;
    assign acertou_jogada = (jogada_reg == rom(endereco[1:0]));
    assign fim_seq        = (endereco == limite);
    assign ult_rodada     = (limite == (modo_reg ? ULT_DEMO : ULT_NORMAL));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= prox;
    end

    always_comb begin
        prox         = estado;
        carrega_modo = 1'b0;
        zera_lim     = 1'b0;
        inc_lim      = 1'b0;
        zera_end     = 1'b0;
        inc_end      = 1'b0;
        zera_timer   = 1'b0;
        inc_timer    = 1'b0;
        carrega_jog  = 1'b0;
        case (estado)
            INICIAL: if (jogar) prox = PREPARACAO;
            PREPARACAO: begin
                carrega_modo = 1'b1;
                zera_lim     = 1'b1;
                prox         = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                zera_end   = 1'b1;
                zera_timer = 1'b1;
                prox       = ESPERA;
            end
            ESPERA: begin
                inc_timer = 1'b1;
                if (jogada) begin
                    carrega_jog = 1'b1;
                    prox        = COMPARA;
                end else if (timer == TIMER_FIM) begin
                    prox = FIM_TIMEOUT;
                end
            end
            COMPARA: begin
                if (!acertou_jogada) prox = FIM_ERROU;
                else if (fim_seq)    prox = FIM_RODADA;
                else                 prox = PROXIMO;
            end
            PROXIMO: begin
                inc_end    = 1'b1;
                zera_timer = 1'b1;
                prox       = ESPERA;
            end
            FIM_RODADA: begin
                if (ult_rodada) begin
                    prox = FIM_ACERTOU;
                end else begin
                    inc_lim = 1'b1;
                    prox    = INICIA_RODADA;
                end
            end
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (jogar) prox = PREPARACAO;
            default: prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco   <= '0;
            limite     <= '0;
            timer      <= '0;
            modo_reg   <= 1'b0;
            botoes_ant <= 1'b0;
            jogada_reg <= '0;
        end else begin
            botoes_ant <= |botoes;
            if (carrega_modo) modo_reg <= modo;
            if (zera_lim)     limite <= '0;
            else if (inc_lim) limite <= limite + 4'd1;
            if (zera_end)     endereco <= '0;
            else if (inc_end) endereco <= endereco + 4'd1;
            if (zera_timer)     timer <= '0;
            else if (inc_timer) timer <= timer + 1'b1;
            if (carrega_jog) jogada_reg <= botoes;
        end
    end

    // Flags are decoded from the end states, so they hold until preparacao or reset.
    assign ganhou  = (estado == FIM_ACERTOU);
    assign perdeu  = (estado == FIM_ERROU);
    assign timeout = (estado == FIM_TIMEOUT);
    assign pronto  = ganhou | perdeu | timeout;
    assign leds    = (estado == ESPERA) ? botoes : 4'b0000;

    // Comparators are masked while idle so that every 1-bit output reads 0 out of reset
    // (endereco == limite is trivially true when both are cleared).
    assign ativo                  = (estado != INICIAL);
    assign db_igual               = ativo & (botoes == rom(endereco[1:0]));
    assign db_enderecoIgualLimite = ativo & fim_seq;
    assign db_timeout             = timeout;
    assign db_modo                = modo_reg;
    assign db_contagem            = hex7seg(endereco);
    assign db_memoria             = hex7seg(rom(endereco[1:0]));
    assign db_estado              = hex7seg(estado);
    assign db_limite_view         = hex7seg(limite);

endmodule

// File: tb/tb_jogo_sequencias.sv
module tb_jogo_sequencias;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic       modo = 1'b0;
    logic       ganhou, perdeu, pronto, timeout, db_igual;
    logic       db_enderecoIgualLimite, db_timeout, db_modo;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_limite_view;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic g;
        logic p;
        logic t;
    } res_t;
    res_t exp_q[$];

    jogo_sequencias dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .modo(modo),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds), .timeout(timeout),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_limite_view(db_limite_view),
        .db_enderecoIgualLimite(db_enderecoIgualLimite), .db_timeout(db_timeout),
        .db_modo(db_modo)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int v);
        case (v)
            0:  seg = 7'b1000000;  1:  seg = 7'b1111001;
            2:  seg = 7'b0100100;  3:  seg = 7'b0110000;
            4:  seg = 7'b0011001;  5:  seg = 7'b0010010;
            6:  seg = 7'b0000010;  7:  seg = 7'b1111000;
            8:  seg = 7'b0000000;  9:  seg = 7'b0010000;
            10: seg = 7'b0001000;  11: seg = 7'b0000011;
            12: seg = 7'b1000110;  13: seg = 7'b0100001;
            14: seg = 7'b0000110;  default: seg = 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] exp_rom(input int i);
        case (i % 4)
            0: exp_rom = 4'b0001;
            1: exp_rom = 4'b0010;
            2: exp_rom = 4'b0100;
            default: exp_rom = 4'b1000;
        endcase
    endfunction

    task automatic apply_reset();
        botoes = 4'b0000;
        jogar  = 1'b0;
        reset  = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic start(input logic m);
        modo  = m;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int gap);
        botoes = b;
        repeat (hold) @(negedge clock);
        botoes = 4'b0000;
        repeat (gap) @(negedge clock);
    endtask

    task automatic play_rounds(input int first_r, input int last_r);
        for (int r = first_r; r <= last_r; r++)
            for (int i = 0; i <= r; i++)
                press(exp_rom(i), 10, 20);
    endtask

    // Waits for pronto; an expired budget is reported as a failed comparison.
    task automatic wait_pronto(input string name, input int budget);
        int n;
        n = 0;
        while (pronto !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        total_cnt++;
        if (pronto !== 1'b1) $display("FAIL %s_pronto: got %b expected 1 within %0d clocks", name, pronto, budget);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        botoes = 4'b0000;
        jogar = 1'b0;
        repeat (5) @(negedge clock);
        total_cnt++;
        if ({ganhou, perdeu, pronto, timeout, db_igual, db_enderecoIgualLimite, db_timeout, db_modo} !== 8'b0)
            $display("FAIL reset_flags: got %b expected 00000000",
                     {ganhou, perdeu, pronto, timeout, db_igual, db_enderecoIgualLimite, db_timeout, db_modo});
        else pass_cnt++;
        total_cnt++;
        if (leds !== 4'b0000) $display("FAIL reset_leds: got %b expected 0000", leds);
        else pass_cnt++;
        total_cnt++;
        if (db_estado !== seg(0)) $display("FAIL reset_estado: got %b expected %b", db_estado, seg(0));
        else pass_cnt++;
        total_cnt++;
        if (db_contagem !== seg(0) || db_limite_view !== seg(0))
            $display("FAIL reset_end_lim: got %b/%b expected %b", db_contagem, db_limite_view, seg(0));
        else pass_cnt++;
        total_cnt++;
        if (db_memoria !== seg(1)) $display("FAIL reset_memoria: got %b expected %b", db_memoria, seg(1));
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_demo_win();
        res_t e;
        apply_reset();
        exp_q.push_back('{g: 1'b1, p: 1'b0, t: 1'b0});
        start(1'b1);
        total_cnt++;
        if (db_estado !== seg(3)) $display("FAIL win_first_espera: got %b expected %b", db_estado, seg(3));
        else pass_cnt++;
        play_rounds(0, 3);
        wait_pronto("win", 100);
        e = exp_q.pop_front();
        total_cnt++;
        if ({ganhou, perdeu, timeout} !== {e.g, e.p, e.t})
            $display("FAIL win_result: got g/p/t=%b%b%b expected %b%b%b", ganhou, perdeu, timeout, e.g, e.p, e.t);
        else pass_cnt++;
        total_cnt++;
        if (db_estado !== seg(10)) $display("FAIL win_estado: got %b expected %b", db_estado, seg(10));
        else pass_cnt++;
        // Flags hold while jogar stays low.
        repeat (30) @(negedge clock);
        total_cnt++;
        if ({ganhou, pronto} !== 2'b11) $display("FAIL win_hold: got %b expected 11", {ganhou, pronto});
        else pass_cnt++;
        // A new start clears the flags.
        start(1'b1);
        total_cnt++;
        if ({ganhou, perdeu, pronto, timeout} !== 4'b0000)
            $display("FAIL restart_clear: got %b expected 0000", {ganhou, perdeu, pronto, timeout});
        else pass_cnt++;
    endtask

    task automatic test_normal_lose();
        res_t e;
        apply_reset();
        exp_q.push_back('{g: 1'b0, p: 1'b1, t: 1'b0});
        start(1'b0);
        play_rounds(0, 1);
        total_cnt++;
        if (db_limite_view !== seg(2)) $display("FAIL lose_limite: got %b expected %b", db_limite_view, seg(2));
        else pass_cnt++;
        press(4'b0001, 10, 20);
        press(4'b0010, 10, 20);
        press(4'b1011, 10, 20);
        wait_pronto("lose", 100);
        e = exp_q.pop_front();
        total_cnt++;
        if ({ganhou, perdeu, timeout} !== {e.g, e.p, e.t})
            $display("FAIL lose_result: got g/p/t=%b%b%b expected %b%b%b", ganhou, perdeu, timeout, e.g, e.p, e.t);
        else pass_cnt++;
        total_cnt++;
        if (db_estado !== seg(14)) $display("FAIL lose_estado: got %b expected %b", db_estado, seg(14));
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        res_t e;
        apply_reset();
        exp_q.push_back('{g: 1'b0, p: 1'b0, t: 1'b1});
        modo  = 1'b0;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        // Espera is entered on edge 3 with timer 0; edge 3+5000 leaves it.
        repeat (5001) @(negedge clock);
        total_cnt++;
        if (db_estado !== seg(3)) $display("FAIL timeout_early: got %b expected %b", db_estado, seg(3));
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (db_estado !== seg(15)) $display("FAIL timeout_edge: got %b expected %b", db_estado, seg(15));
        else pass_cnt++;
        repeat (500) @(negedge clock);
        wait_pronto("timeout", 10);
        e = exp_q.pop_front();
        total_cnt++;
        if ({ganhou, perdeu, timeout, db_timeout} !== {e.g, e.p, e.t, e.t})
            $display("FAIL timeout_result: got g/p/t/dbt=%b%b%b%b expected %b%b%b%b",
                     ganhou, perdeu, timeout, db_timeout, e.g, e.p, e.t, e.t);
        else pass_cnt++;
    endtask

    task automatic test_modo_latch();
        res_t e;
        apply_reset();
        exp_q.push_back('{g: 1'b1, p: 1'b0, t: 1'b0});
        start(1'b1);
        repeat (6) @(negedge clock);
        modo = 1'b0;
        @(negedge clock);
        total_cnt++;
        if (db_modo !== 1'b1) $display("FAIL modo_latched: got %b expected 1", db_modo);
        else pass_cnt++;
        play_rounds(0, 3);
        wait_pronto("modo", 100);
        e = exp_q.pop_front();
        total_cnt++;
        if ({ganhou, perdeu, timeout, db_modo} !== {e.g, e.p, e.t, 1'b1})
            $display("FAIL modo_result: got g/p/t/modo=%b%b%b%b expected %b%b%b1",
                     ganhou, perdeu, timeout, db_modo, e.g, e.p, e.t);
        else pass_cnt++;
    endtask

    task automatic test_hold_single_press();
        apply_reset();
        start(1'b1);
        press(4'b0001, 10, 20);
        botoes = 4'b0001;
        #1;
        total_cnt++;
        if (leds !== 4'b0001) $display("FAIL hold_leds_echo: got %b expected 0001", leds);
        else pass_cnt++;
        repeat (10) @(negedge clock);
        total_cnt++;
        if (db_contagem !== seg(1)) $display("FAIL hold_endereco: got %b expected %b", db_contagem, seg(1));
        else pass_cnt++;
        total_cnt++;
        if (db_estado !== seg(3) || leds !== 4'b0001)
            $display("FAIL hold_espera: got estado %b leds %b expected %b 0001", db_estado, leds, seg(3));
        else pass_cnt++;
        total_cnt++;
        if (db_igual !== 1'b0 || db_enderecoIgualLimite !== 1'b1)
            $display("FAIL hold_cmp_wrong: got igual %b eq_lim %b expected 0 1", db_igual, db_enderecoIgualLimite);
        else pass_cnt++;
        botoes = 4'b0000;
        repeat (20) @(negedge clock);
        botoes = 4'b0010;
        #1;
        total_cnt++;
        if (db_igual !== 1'b1) $display("FAIL hold_cmp_right: got %b expected 1", db_igual);
        else pass_cnt++;
        botoes = 4'b0000;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid_game();
        apply_reset();
        start(1'b1);
        press(4'b0001, 10, 20);
        press(4'b0001, 10, 20);
        total_cnt++;
        if (db_limite_view !== seg(1) || db_contagem !== seg(1))
            $display("FAIL mid_before: got lim %b end %b expected %b", db_limite_view, db_contagem, seg(1));
        else pass_cnt++;
        botoes = 4'b0010;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (db_estado !== seg(0)) $display("FAIL mid_estado: got %b expected %b", db_estado, seg(0));
        else pass_cnt++;
        total_cnt++;
        if (db_limite_view !== seg(0) || db_contagem !== seg(0))
            $display("FAIL mid_lim_end: got %b/%b expected %b", db_limite_view, db_contagem, seg(0));
        else pass_cnt++;
        total_cnt++;
        if ({ganhou, perdeu, pronto, timeout, db_enderecoIgualLimite, db_timeout, db_modo, db_igual} !== 8'b0 ||
            leds !== 4'b0000)
            $display("FAIL mid_outputs: got %b leds %b expected 00000000 0000",
                     {ganhou, perdeu, pronto, timeout, db_enderecoIgualLimite, db_timeout, db_modo, db_igual}, leds);
        else pass_cnt++;
        botoes = 4'b0000;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_demo_win();
        test_normal_lose();
        test_timeout();
        test_modo_latch();
        test_hold_single_press();
        test_reset_mid_game();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
